uart_byte_rx: RTL and testbench

Serial-to-byte UART receiver for the `uart_rx_i` pin of the top level: 8 data bits, LSB first, 1 stop bit, optional even parity. It sits in the system clock domain and synchronises the asynchronous line. It hands each received byte to the command/register logic over a valid/ready handshake. It reports framing, parity and overrun errors as single-cycle pulses.

---
 rtl/uart_byte_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// 8-bit UART receiver (LSB first, 1 stop bit) with a valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between d7 and the stop bit.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 1074
) (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_sample;
    logic               w_deliver;
    logic               w_frame_err;
    logic               w_overrun;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bad;
    logic               r_parity_err;
    logic               w_parity_err;
`endif

    // Idle-high line, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_deliver    = 1'b0;
        w_frame_err  = 1'b0;
        w_overrun    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_err = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_state_next = S_START;
            end
            S_START: begin
                w_sample = (r_baud_cnt == HALF_LAST);
                if (w_sample) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                w_sample = (r_baud_cnt == BIT_LAST);
                if (w_sample && r_bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_sample = (r_baud_cnt == BIT_LAST);
                if (w_sample) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                w_sample = (r_baud_cnt == BIT_LAST);
                if (w_sample) begin
                    if (!r_rx_s) begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_parity_err = 1'b1;
                        w_state_next = S_IDLE;
`endif
                    end else begin
                        w_state_next = S_IDLE;
                        // A same-cycle accept frees the holding register for the new byte.
                        if (!r_valid || ready_i) w_deliver = 1'b1;
                        else                     w_overrun = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_WAIT_HIGH: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                    r_par_bad  <= 1'b0;
`endif
                end
                default: begin
                    r_baud_cnt <= w_sample ? '0 : r_baud_cnt + CNT_W'(1);
                    if (w_sample && r_state == S_DATA) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
`ifdef UART_RX_PARITY_EN
                    if (w_sample && r_state == S_PARITY) r_par_bad <= (r_rx_s != ^r_shift);
`endif
                end
            endcase

            if (w_deliver) r_data <= r_shift;

            if (w_deliver)              r_valid <= 1'b1;
            else if (r_valid && ready_i) r_valid <= 1'b0;

            r_frame_err  <= w_frame_err;
            r_overrun    <= w_overrun;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = (r_state != S_IDLE);
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_byte_rx;

    localparam int CLKS = 16;
    localparam int HALF = CLKS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Pin edge -> t0 is 3 clock edges (2 synchroniser + idle check); stop sample follows.
    localparam int RISE_OFF = 3 + HALF + (9 + PAR) * CLKS;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_start_cyc = 0;
    int last_rise_cyc = -1;
    int vh_cnt = 0;
    int obs_frame = 0, obs_par = 0, obs_ovr = 0;
    int exp_frame = 0, exp_par = 0, exp_ovr = 0;
    logic rand_ready = 1'b0;
    logic [7:0] exp_q[$];

    uart_byte_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .sys_clk_i   (clk),
        .rst_i       (rst),
        .uart_rx_i   (uart_rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) uart_rx = 1'b1;
`endif
        drive_bit(stop_bit);
        uart_rx = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every accept, tallies error pulses.
    initial begin
        logic prev_valid;
        logic [7:0] exp_b;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (valid_o) begin
                    vh_cnt++;
                    if (!prev_valid) last_rise_cyc = cyc;
                end
                if (valid_o && ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL accept_unexpected: got 0x%0h expected no byte", data_o);
                    end else begin
                        exp_b = exp_q.pop_front();
                        checks--;
                        check("accept_data", {24'd0, data_o}, {24'd0, exp_b});
                    end
                end
                if (frame_err_o)  obs_frame++;
                if (parity_err_o) obs_par++;
                if (overrun_o)    obs_ovr++;
                if ($countones({frame_err_o, parity_err_o, overrun_o}) > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_exclusive: got %b expected at most one", {frame_err_o, parity_err_o, overrun_o});
                end
            end
            prev_valid = valid_o && !rst;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_pulses(input string tag);
        check({tag, "_frame_err_cnt"}, obs_frame, exp_frame);
        check({tag, "_parity_err_cnt"}, obs_par, exp_par);
        check({tag, "_overrun_cnt"}, obs_ovr, exp_ovr);
    endtask

    initial begin
        int n, vh0;
        rst = 1'b1;
        uart_rx = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_o}, 32'h0);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_pulses", {frame_err_o, parity_err_o, overrun_o}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic frame with latency and single-cycle valid.
        vh0 = vh_cnt;
        exp_q.push_back(8'hA5);
        n = cyc;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (2) @(negedge clk);
                check("busy_before_t0", busy_o, 0);
                @(negedge clk);
                check("busy_at_t0p1", busy_o, 1);
            end
        join
        repeat (5) @(negedge clk);
        check("a5_rise_cycle", last_rise_cyc, n + RISE_OFF);
        check("a5_valid_cycles", vh_cnt - vh0, 1);
        check("a5_busy_idle", busy_o, 0);
        check_pulses("a5");

        // False start: short low glitch.
        vh0 = vh_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy", busy_o, 0);
        check("glitch_no_valid", vh_cnt - vh0, 0);
        check_pulses("glitch");

        // Framing error followed by a break, then a good frame.
        vh0 = vh_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        exp_frame++;
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        check("break_busy", busy_o, 1);
        repeat (20) @(negedge clk);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        check("break_released_busy", busy_o, 0);
        check("break_no_valid", vh_cnt - vh0, 0);
        check_pulses("break");
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("x55_drained", exp_q.size(), 0);

        // Overrun with consumer stalled.
        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        exp_ovr++;
        repeat (5) @(negedge clk);
        check("ovr_data_held", {24'd0, data_o}, 32'h11);
        check("ovr_valid_held", valid_o, 1);
        check_pulses("ovr");
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("ovr_accepted", exp_q.size(), 0);
        check("ovr_valid_low", valid_o, 0);

        // Accept exactly on the stop-sample cycle of the next byte.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                repeat (RISE_OFF - 1) @(negedge clk);
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("coll_valid", valid_o, 1);
        check("coll_data", {24'd0, data_o}, 32'h22);
        check("coll_queue", exp_q.size(), 1);
        check_pulses("coll");
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("coll_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        vh0 = vh_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        exp_par++;
        repeat (5) @(negedge clk);
        check("par_bad_no_valid", vh_cnt - vh0, 0);
        check_pulses("par_bad");
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("par_good_drained", exp_q.size(), 0);
`endif

        // Reset mid-frame with a byte pending.
        ready_i = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        uart_rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_data", {24'd0, data_o}, 32'h0);
        check("mid_rst_busy", busy_o, 0);
        rst = 1'b0;
        ready_i = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_busy", busy_o, 0);
        check_pulses("post_rst");
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("x7e_drained", exp_q.size(), 0);

        // Randomised bytes, gaps and consumer back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            int gap;
            b = 8'($urandom);
            gap = $urandom_range(0, 20);
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
            repeat (gap) @(negedge clk);
        end
        for (int w = 0; w < 400 && exp_q.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        rand_ready = 1'b0;
        #1 ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_drained", exp_q.size(), 0);
        check_pulses("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
